// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and default widths for uart_tx and uart_rx
package uart_pkg;

   localparam int UART_DATA_WIDTH = 8;
   localparam int UART_DIV_WIDTH  = 16;

   localparam logic UART_IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

endpackage

// File: rtl/uart_baud_counter.sv
// rtl/uart_baud_counter.sv - bit-time counter; latches the divisor at frame start and pulses bit_end every D cycles
module uart_baud_counter
   import uart_pkg::*;
#(
   parameter int DIV_WIDTH = UART_DIV_WIDTH
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 load_i,
   input  logic [DIV_WIDTH-1:0] div_i,
   input  logic                 run_i,
   output logic                 bit_end_o
);

   logic [DIV_WIDTH-1:0] div_q, div_d;
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

   assign bit_end_o = run_i && (cnt_q == div_q - 1'b1);

   // A load coincides with the last bit_end of the previous frame; load wins so the new frame starts at 0.
   always_comb begin
      div_d = div_q;
      cnt_d = cnt_q;
      if (load_i) begin
         div_d = (div_i == '0) ? DIV_WIDTH'(1) : div_i;
         cnt_d = '0;
      end else if (run_i) begin
         cnt_d = bit_end_o ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         div_q <= DIV_WIDTH'(1);
         cnt_q <= '0;
      end else begin
         div_q <= div_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter draining the TX FIFO into start/data/parity/stop frames
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = UART_DATA_WIDTH,
   parameter int DIV_WIDTH  = UART_DIV_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  enable_i,
   input  logic [DIV_WIDTH-1:0]  baud_div_i,
   input  logic                  parity_en_i,
   input  logic                  parity_odd_i,
   input  logic                  two_stop_i,
   input  logic [DATA_WIDTH-1:0] fifo_data_i,
   input  logic                  fifo_empty_i,
   output logic                  fifo_pop_o,
   output logic                  tx_o,
   output logic                  busy_o,
   output logic                  tx_done_o
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   uart_state_e           state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic                  parity_bit_q, parity_bit_d;
   logic                  parity_en_q, parity_en_d;
   logic                  two_stop_q, two_stop_d;
   logic                  pop_q, pop_d;
   logic                  start_frame;
   logic                  bit_end;
   logic                  last_stop;
   logic                  running;

   assign running   = (state_q != ST_IDLE);
   assign last_stop = (bit_cnt_q == CNT_W'(two_stop_q));

   uart_baud_counter #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_baud (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .load_i    (start_frame),
      .div_i     (baud_div_i),
      .run_i     (running),
      .bit_end_o (bit_end)
   );

   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      bit_cnt_d    = bit_cnt_q;
      parity_bit_d = parity_bit_q;
      parity_en_d  = parity_en_q;
      two_stop_d   = two_stop_q;
      pop_d        = 1'b0;
      start_frame  = 1'b0;
      tx_done_o    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            start_frame = enable_i && !fifo_empty_i;
         end
         ST_START: begin
            if (bit_end) begin
               state_d   = ST_DATA;
               bit_cnt_d = '0;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                  bit_cnt_d = '0;
                  state_d   = parity_en_q ? ST_PARITY : ST_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               state_d   = ST_STOP;
               bit_cnt_d = '0;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               if (last_stop) begin
                  tx_done_o   = 1'b1;
                  start_frame = enable_i && !fifo_empty_i;
                  state_d     = ST_IDLE;
                  bit_cnt_d   = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Parity is folded to a single bit at load so odd/even never needs to be held.
      if (start_frame) begin
         state_d      = ST_START;
         shift_d      = fifo_data_i;
         parity_bit_d = (^fifo_data_i) ^ parity_odd_i;
         parity_en_d  = parity_en_i;
         two_stop_d   = two_stop_i;
         bit_cnt_d    = '0;
         pop_d        = 1'b1;
      end
   end

   always_comb begin
      tx_o = UART_IDLE_LEVEL;
      case (state_q)
         ST_START:  tx_o = ~UART_IDLE_LEVEL;
         ST_DATA:   tx_o = shift_q[0];
         ST_PARITY: tx_o = parity_bit_q;
         default:   tx_o = UART_IDLE_LEVEL;
      endcase
   end

   assign busy_o     = running;
   assign fifo_pop_o = pop_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ST_IDLE;
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         parity_bit_q <= 1'b0;
         parity_en_q  <= 1'b0;
         two_stop_q   <= 1'b0;
         pop_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         bit_cnt_q    <= bit_cnt_d;
         parity_bit_q <= parity_bit_d;
         parity_en_q  <= parity_en_d;
         two_stop_q   <= two_stop_d;
         pop_q        <= pop_d;
      end
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter that drains the TX FIFO and serialises each byte onto the TX line as a standard asynchronous frame.
- The frame is start bit, 8 data bits LSB first, an optional parity bit, then 1 or 2 stop bits.
- Sits directly downstream of the TX FIFO:
  - consumes the FIFO's DATA_OUT and EMPTY;
  - drives the FIFO's POP.
- The baud rate is a runtime cycles-per-bit divisor, so the host can reprogram it without resynthesis.

Parameters:
- DATA_WIDTH, 8, payload bits per frame; must match the FIFO's DATA_WIDTH.
- DIV_WIDTH, 16, width of the BAUD_DIV input.

Ports:
- CLK  in  1  single clock for all logic.
- RESET_N  in  1  asynchronous, active-low reset.
- ENABLE  in  1  when 1, new frames may start; when 0, the current frame completes and no new pop occurs.
- BAUD_DIV  in  DIV_WIDTH  clock cycles per bit; 0 is treated as 1.
- PARITY_EN  in  1  1 = append a parity bit.
- PARITY_ODD  in  1  1 = odd parity, 0 = even parity.
- TWO_STOP  in  1  1 = two stop bits, 0 = one.
- FIFO_DATA  in  DATA_WIDTH  FIFO head word; valid whenever FIFO_EMPTY = 0.
- FIFO_EMPTY  in  1  FIFO empty flag.
- FIFO_POP  out  1  one-cycle pulse that advances the FIFO read pointer.
- TX  out  1  serial line; idles high.
- BUSY  out  1  1 while a frame is in progress (START through the last STOP).
- TX_DONE  out  1  one-cycle pulse in the final cycle of the last stop bit.

Behaviour:
- Reset (asynchronous, RESET_N = 0):
  - TX = 1, BUSY = 0, FIFO_POP = 0, TX_DONE = 0.
  - State = IDLE; bit counter and baud counter = 0.
  - Applies immediately mid-frame: the partial frame is abandoned and no further pop is issued.
- States: IDLE, START, DATA, PARITY, STOP, all held in registers.
- Frame start (IDLE):
  - Frame starts in cycle N when ENABLE = 1 and FIFO_EMPTY = 0.
  - At edge N+1: FIFO_DATA loads into the shift register; PARITY_EN, PARITY_ODD, TWO_STOP and the effective divisor are latched; state becomes START; TX = 0; BUSY = 1.
  - FIFO_POP = 1 during cycle N+1 only, so the FIFO advances at the end of N+1.
  - Latency from FIFO non-empty to the TX falling edge is 1 cycle.
- Bit timing:
  - Every bit (start, data, parity, stop) lasts exactly the latched divisor D cycles.
  - The baud counter runs 0..D-1 and the state or bit index advances when it reaches D-1.
  - BAUD_DIV changes mid-frame are ignored; D is re-latched at each frame start.
- DATA: shifts right, TX = shift[0]; after DATA_WIDTH bits the state goes to PARITY if parity is enabled, otherwise to STOP.
- PARITY: TX = XOR of the latched data bits, inverted when odd parity is selected.
- STOP: TX = 1 for one or two bit-times.
  - In the last cycle of the final stop bit, TX_DONE = 1.
  - If ENABLE = 1 and FIFO_EMPTY = 0 in that cycle, the next frame starts directly: START at the next edge plus a FIFO_POP pulse, with zero idle gap.
  - Otherwise the state goes to IDLE and BUSY drops.
- ENABLE deasserted mid-frame: the frame completes unchanged and no pop follows.
- FIFO_POP is never asserted while FIFO_EMPTY was 1 in the deciding cycle; at most one pop is issued per frame.
- Frame length: (1 + DATA_WIDTH + PARITY_EN + 1 + TWO_STOP) × D cycles.

Decomposition:
- Package uart_pkg:
  - state encoding (IDLE/START/DATA/PARITY/STOP);
  - UART_IDLE_LEVEL = 1'b1;
  - default DATA_WIDTH/DIV_WIDTH constants, shared with the future uart_rx.
- One sub-module, uart_baud_counter:
  - loads D on frame start;
  - emits a bit_end pulse every D cycles;
  - clamps a divisor of 0 to 1.
- The FSM, shift register and parity live in uart_tx.

Test Plan:
- Single byte: BAUD_DIV = 4, no parity, 1 stop; push 0xA5 into an empty FIFO.
  - TX holds 0,1,0,1,0,0,1,0,1,1 for 4 cycles each (40 cycles total).
  - One FIFO_POP pulse, 1 cycle after EMPTY falls.
  - TX_DONE fires in cycle 40; BUSY returns to 0.
- Back-to-back: push 0x00, 0xFF, 0x55 with BAUD_DIV = 2.
  - 3 pops; 60 contiguous cycles of framing with no idle high between frames.
  - FIFO ends EMPTY.
- Parity: 0x07 with even parity gives parity bit 1; with odd parity gives 0.
  - TWO_STOP = 1 yields 2 stop bit-times.
  - Frame = 12 × D cycles.
- Divisor clamp: BAUD_DIV = 0 behaves identically to BAUD_DIV = 1.
  - Byte 0x3C is sent in 10 cycles.
- Reset mid-frame: RESET_N = 0 during data bit 3.
  - TX = 1 and BUSY = 0 immediately (asynchronous).
  - After release, the next FIFO entry is sent intact with exactly one new pop.
- ENABLE drop: deassert ENABLE mid-frame with 2 entries queued.
  - The current frame completes and there are no further pops.
  - On re-enable, the queued byte starts 1 cycle later.
